// File: rtl/vctrl_config_sequencer.sv
// Write-port sequencer for the vector control register file: round-robin between scalar
// writes and matmul shape commands (expanded to mask writes). Optional VCTRL_SETVL_EN adds a vl write.
module vctrl_config_sequencer #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int MMSIZE      = 8,
  parameter int LOG2MMSIZE  = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_req,
  input  logic [LOG2NUMREGS-1:0] s_reg,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   s_gnt,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [LOG2MMSIZE:0]    cfg_arows,
  input  logic [LOG2MMSIZE:0]    cfg_acols,
  input  logic [LOG2MMSIZE:0]    cfg_bcols,
  output logic [LOG2NUMREGS-1:0] c_reg,
  output logic [WIDTH-1:0]       c_writedatain,
  output logic                   c_we,
  output logic                   busy,
  output logic                   done
);
  localparam int FW = LOG2MMSIZE + 1;

  typedef enum logic [2:0] {
    IDLE,
    W_AROWS,
    W_ACOLS,
    W_BCOLS
`ifdef VCTRL_SETVL_EN
    , W_VL
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_cfg_q, last_cfg_d;
  logic [FW-1:0]          acols_q, acols_d;
  logic [FW-1:0]          bcols_q, bcols_d;
  logic                   c_we_q, c_we_d;
  logic [LOG2NUMREGS-1:0] c_reg_q, c_reg_d;
  logic [WIDTH-1:0]       c_data_q, c_data_d;
  logic                   done_q, done_d;

`ifdef VCTRL_SETVL_EN
  logic [FW-1:0]          arows_q, arows_d;
  logic [2*FW-1:0]        vl_prod;
  assign vl_prod = (2*FW)'(arows_q) * (2*FW)'(bcols_q);
`endif

  // Thermometer mask; fields >= MMSIZE saturate naturally since only MMSIZE bits are produced.
  function automatic logic [WIDTH-1:0] mask(input logic [FW-1:0] n);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MMSIZE; i++) m[i] = (i < 32'(n));
    return m;
  endfunction

  // The output registers are loaded one state ahead, so the write shown in
  // state W_X is the one computed while leaving the previous state.
  always_comb begin
    state_d    = state_q;
    last_cfg_d = last_cfg_q;
    acols_d    = acols_q;
    bcols_d    = bcols_q;
`ifdef VCTRL_SETVL_EN
    arows_d    = arows_q;
`endif
    c_we_d     = 1'b0;
    c_reg_d    = c_reg_q;
    c_data_d   = c_data_q;
    done_d     = 1'b0;
    s_gnt      = 1'b0;
    cfg_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (resetn) begin
          if (s_req && (!cfg_valid || last_cfg_q)) begin
            s_gnt      = 1'b1;
            last_cfg_d = 1'b0;
            c_we_d     = 1'b1;
            c_reg_d    = s_reg;
            c_data_d   = s_data;
          end else if (cfg_valid) begin
            cfg_ready  = 1'b1;
            last_cfg_d = 1'b1;
            acols_d    = cfg_acols;
            bcols_d    = cfg_bcols;
`ifdef VCTRL_SETVL_EN
            arows_d    = cfg_arows;
`endif
            c_we_d     = 1'b1;
            c_reg_d    = LOG2NUMREGS'(31);
            c_data_d   = mask(cfg_arows);
            state_d    = W_AROWS;
          end
        end
      end
      W_AROWS: begin
        c_we_d   = 1'b1;
        c_reg_d  = LOG2NUMREGS'(30);
        c_data_d = mask(acols_q);
        state_d  = W_ACOLS;
      end
      W_ACOLS: begin
        c_we_d   = 1'b1;
        c_reg_d  = LOG2NUMREGS'(29);
        c_data_d = mask(bcols_q);
`ifndef VCTRL_SETVL_EN
        done_d   = 1'b1;
`endif
        state_d  = W_BCOLS;
      end
      W_BCOLS: begin
`ifdef VCTRL_SETVL_EN
        c_we_d   = 1'b1;
        c_reg_d  = '0;
        c_data_d = WIDTH'(vl_prod);
        done_d   = 1'b1;
        state_d  = W_VL;
`else
        state_d  = IDLE;
`endif
      end
`ifdef VCTRL_SETVL_EN
      W_VL:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      last_cfg_q <= 1'b1;
      acols_q    <= '0;
      bcols_q    <= '0;
`ifdef VCTRL_SETVL_EN
      arows_q    <= '0;
`endif
      c_we_q     <= 1'b0;
      c_reg_q    <= '0;
      c_data_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_cfg_q <= last_cfg_d;
      acols_q    <= acols_d;
      bcols_q    <= bcols_d;
`ifdef VCTRL_SETVL_EN
      arows_q    <= arows_d;
`endif
      c_we_q     <= c_we_d;
      c_reg_q    <= c_reg_d;
      c_data_q   <= c_data_d;
      done_q     <= done_d;
    end
  end

  assign c_we          = c_we_q;
  assign c_reg         = c_reg_q;
  assign c_writedatain = c_data_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_vctrl_config_sequencer.sv
// Self-checking bench for vctrl_config_sequencer: per-cycle write-queue model plus directed literal checks.
module tb_vctrl_config_sequencer;
  localparam int WIDTH = 32, L2R = 5, MMSIZE = 8, L2M = 3, FW = L2M + 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             s_req = 1'b0;
  logic [L2R-1:0]   s_reg = '0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_gnt;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [FW-1:0]    cfg_arows = '0, cfg_acols = '0, cfg_bcols = '0;
  logic [L2R-1:0]   c_reg;
  logic [WIDTH-1:0] c_writedatain;
  logic             c_we, busy, done;

  vctrl_config_sequencer #(.WIDTH(WIDTH), .LOG2NUMREGS(L2R), .MMSIZE(MMSIZE), .LOG2MMSIZE(L2M)) dut (
    .clk(clk), .resetn(resetn),
    .s_req(s_req), .s_reg(s_reg), .s_data(s_data), .s_gnt(s_gnt),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_arows(cfg_arows), .cfg_acols(cfg_acols), .cfg_bcols(cfg_bcols),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mmask(input int n);
    if (n >= MMSIZE) return (32'd1 << MMSIZE) - 32'd1;
    return (32'd1 << n) - 32'd1;
  endfunction

  // Model: queue of writes still owed for the cycles after a shape command is taken.
  typedef struct packed {
    logic [L2R-1:0] r;
    logic [31:0]    d;
    logic           dn;
  } wr_t;

  wr_t            pend[$];
  logic           m_we = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_lastcfg = 1'b1;
  logic [L2R-1:0] m_reg = '0;
  logic [31:0]    m_data = '0;

  always @(negedge clk) begin
    logic gs, gc;
    wr_t  w;
    if (!resetn) begin
      chk("rst_c_we", 32'(c_we), 32'd0);
      chk("rst_c_reg", 32'(c_reg), 32'd0);
      chk("rst_c_data", c_writedatain, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s_gnt", 32'(s_gnt), 32'd0);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      pend.delete();
      m_we = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_lastcfg = 1'b1;
    end else begin
      chk("m_c_we", 32'(c_we), 32'(m_we));
      if (m_we) begin
        chk("m_c_reg", 32'(c_reg), 32'(m_reg));
        chk("m_c_data", c_writedatain, m_data);
      end
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_done", 32'(done), 32'(m_done));
      gs = !m_busy && s_req && (!cfg_valid || m_lastcfg);
      gc = !m_busy && cfg_valid && !gs;
      chk("m_s_gnt", 32'(s_gnt), 32'(gs));
      chk("m_cfg_ready", 32'(cfg_ready), 32'(gc));
      if (gs) begin
        m_lastcfg = 1'b0;
        m_we = 1'b1; m_reg = s_reg; m_data = s_data; m_done = 1'b0; m_busy = 1'b0;
      end else begin
        if (gc) begin
          m_lastcfg = 1'b1;
          pend.push_back('{r: L2R'(31), d: mmask(int'(cfg_arows)), dn: 1'b0});
          pend.push_back('{r: L2R'(30), d: mmask(int'(cfg_acols)), dn: 1'b0});
`ifdef VCTRL_SETVL_EN
          pend.push_back('{r: L2R'(29), d: mmask(int'(cfg_bcols)), dn: 1'b0});
          pend.push_back('{r: L2R'(0), d: 32'(int'(cfg_arows) * int'(cfg_bcols)), dn: 1'b1});
`else
          pend.push_back('{r: L2R'(29), d: mmask(int'(cfg_bcols)), dn: 1'b1});
`endif
        end
        if (pend.size() > 0) begin
          w = pend.pop_front();
          m_we = 1'b1; m_reg = w.r; m_data = w.d; m_done = w.dn; m_busy = 1'b1;
        end else begin
          m_we = 1'b0; m_done = 1'b0; m_busy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int a, input int b, input int c);
    cfg_valid = 1'b1;
    cfg_arows = FW'(a);
    cfg_acols = FW'(b);
    cfg_bcols = FW'(c);
  endtask

  task automatic lit_write(input string nm, input int r, input logic [31:0] d, input logic dn);
    @(negedge clk);
    chk({nm, "_we"}, 32'(c_we), 32'd1);
    chk({nm, "_reg"}, 32'(c_reg), 32'(r));
    chk({nm, "_data"}, c_writedatain, d);
    chk({nm, "_done"}, 32'(done), 32'(dn));
  endtask

  int gseq[$];

  initial begin
    #1 resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;

    // Shape (3,8,0)
    tick();
    set_cfg(3, 8, 0);
    @(negedge clk); chk("seq1_ready", 32'(cfg_ready), 32'd1);
    tick(); cfg_valid = 1'b0;
`ifdef VCTRL_SETVL_EN
    lit_write("seq1_w31", 31, 32'h07, 1'b0);
    tick(); lit_write("seq1_w30", 30, 32'hFF, 1'b0);
    tick(); lit_write("seq1_w29", 29, 32'h00, 1'b0);
    tick(); lit_write("seq1_vl", 0, 32'h00, 1'b1);
`else
    lit_write("seq1_w31", 31, 32'h07, 1'b0);
    tick(); lit_write("seq1_w30", 30, 32'hFF, 1'b0);
    tick(); lit_write("seq1_w29", 29, 32'h00, 1'b1);
`endif
    tick(); @(negedge clk);
    chk("seq1_gap_busy", 32'(busy), 32'd0);
    chk("seq1_gap_we", 32'(c_we), 32'd0);

    // Shape (4,15,6): saturation and vl = 24
    tick();
    set_cfg(4, 15, 6);
    @(negedge clk); chk("seq2_ready", 32'(cfg_ready), 32'd1);
    tick(); cfg_valid = 1'b0;
    lit_write("seq2_w31", 31, 32'h0F, 1'b0);
    tick(); lit_write("seq2_sat", 30, 32'hFF, 1'b0);
`ifdef VCTRL_SETVL_EN
    tick(); lit_write("seq2_w29", 29, 32'h3F, 1'b0);
    tick(); lit_write("seq2_vl", 0, 32'd24, 1'b1);
`else
    tick(); lit_write("seq2_w29", 29, 32'h3F, 1'b1);
`endif
    tick(); @(negedge clk); chk("seq2_gap_busy", 32'(busy), 32'd0);

    // Back-to-back scalar writes, including a protected-looking index
    tick();
    s_req = 1'b1; s_reg = 5'd31; s_data = 32'hDEADBEEF;
    @(negedge clk); chk("sc1_gnt", 32'(s_gnt), 32'd1);
    tick(); s_reg = 5'd0; s_data = 32'd5;
    @(negedge clk);
    chk("sc1_reg", 32'(c_reg), 32'd31);
    chk("sc1_data", c_writedatain, 32'hDEADBEEF);
    chk("sc2_gnt", 32'(s_gnt), 32'd1);
    tick(); s_req = 1'b0;
    lit_write("sc2", 0, 32'd5, 1'b0);

    // Reset during W_ACOLS
    tick();
    set_cfg(2, 2, 2);
    tick(); cfg_valid = 1'b0;
    tick();
    s_req = 1'b1; s_reg = 5'd5; s_data = 32'h1234;
    resetn = 1'b0;
    #1;
    chk("arst_we", 32'(c_we), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_gnt", 32'(s_gnt), 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    @(negedge clk); chk("post_rst_gnt", 32'(s_gnt), 32'd1);
    tick(); s_req = 1'b0;
    lit_write("post_rst_wr", 5, 32'h1234, 1'b0);
    tick(); @(negedge clk);
    chk("post_rst_no29", 32'(c_we), 32'd0);
    tick();
    set_cfg(1, 1, 1);
    tick(); cfg_valid = 1'b0;
    lit_write("post_rst_seq", 31, 32'h01, 1'b0);
    repeat (5) tick();

    // Continuous contention from reset
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    s_req = 1'b1; s_reg = 5'd7; s_data = 32'hA5;
    set_cfg(8, 8, 8);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (s_gnt) gseq.push_back(0);
      if (cfg_ready) gseq.push_back(1);
      if (busy) chk("rr_busy_no_gnt", 32'(s_gnt), 32'd0);
      tick();
    end
    s_req = 1'b0; cfg_valid = 1'b0;
    chk("rr_count", 32'(gseq.size() >= 6), 32'd1);
    if (gseq.size() > 0) chk("rr_first_scalar", 32'(gseq[0]), 32'd0);
    for (int i = 1; i < gseq.size(); i++)
      chk("rr_alternate", 32'(gseq[i]), 32'(gseq[i-1] == 0 ? 1 : 0));
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vctrl_config_sequencer.md
Name: vctrl_config_sequencer

Overview:
- Sits in front of the vector control register file's single write port (c_reg / c_writedatain / c_we).
- Arbitrates between two writers:
  - the scalar core's move-to-control writes;
  - matmul shape commands, which the block expands into an atomic sequence of thermometer-mask writes to control registers 31 (a_rows), 30 (a_cols/b_rows) and 29 (b_cols).
- Guarantees the mask triplet is never interleaved with scalar writes.

Parameters:
- WIDTH, 32, control register data width.
- LOG2NUMREGS, 5, control register address width.
- MMSIZE, 8, matmul array dimension (mask width); must equal the mask slice width of the register file.
- LOG2MMSIZE, 3, log2(MMSIZE); shape fields are LOG2MMSIZE+1 bits so the value MMSIZE is representable.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s_req  in  1  scalar write request; held until granted.
- s_reg  in  LOG2NUMREGS  scalar write register index.
- s_data  in  WIDTH  scalar write data.
- s_gnt  out  1  combinational; high in the cycle the scalar write is accepted.
- cfg_valid  in  1  shape command valid; held until cfg_ready.
- cfg_ready  out  1  combinational; high in the cycle the command is accepted.
- cfg_arows  in  LOG2MMSIZE+1  A row count.
- cfg_acols  in  LOG2MMSIZE+1  A column count (= B row count).
- cfg_bcols  in  LOG2MMSIZE+1  B column count.
- c_reg  out  LOG2NUMREGS  register file write index (registered).
- c_writedatain  out  WIDTH  register file write data (registered).
- c_we  out  1  register file write enable (registered).
- busy  out  1  high while a shape sequence is in flight.
- done  out  1  one-cycle pulse coincident with the last sequence write.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, c_we=0, c_reg=0, c_writedatain=0, busy=0, done=0;
  - last_winner=cfg, so the scalar side wins the first tie.
- States: IDLE, W_AROWS, W_ACOLS, W_BCOLS, plus W_VL when VCTRL_SETVL_EN is defined.
- Acceptance happens only in IDLE:
  - Only s_req high: s_gnt=1. Next cycle c_we=1, c_reg=s_reg, c_writedatain=s_data. State stays IDLE, so back-to-back scalar writes can occur every cycle.
  - Only cfg_valid high: cfg_ready=1. The three shape fields are captured. Next state is W_AROWS.
  - Both high: round-robin. The side that did not win the previous arbitration is granted, then last_winner updates. A lone requester always wins and still updates last_winner.
- Sequence states (cfg accepted in cycle T):
  - W_AROWS, cycle T+1: c_we=1, c_reg=31, data=mask(arows).
  - W_ACOLS, cycle T+2: c_we=1, c_reg=30, data=mask(acols).
  - W_BCOLS, cycle T+3: c_we=1, c_reg=29, data=mask(bcols), done=1.
  - W_BCOLS then returns to IDLE.
- busy=1 in every sequence-state cycle. s_gnt=0 and cfg_ready=0 outside IDLE; requesters keep holding.
- mask(n):
  - low n bits set, zero-extended to WIDTH;
  - n=0 gives all zeros;
  - n>=MMSIZE saturates to MMSIZE ones.
- Gaps: at least one IDLE cycle separates consecutive sequences, and c_we=0 in any IDLE cycle with no grant.
- Scalar writes to registers 0 and 29–31 are passed through unmodified; no protection is applied.
- Reset mid-sequence: the state is abandoned immediately. No further sequence writes occur after reset release, and the captured shape is discarded.

Optional Feature:
- Macro: VCTRL_SETVL_EN.
- Defined:
  - W_BCOLS advances to W_VL. W_VL writes c_reg=0 with data = cfg_arows*cfg_bcols, where the product is 2*(LOG2MMSIZE+1) bits zero-extended to WIDTH and uses the unsaturated fields.
  - done moves to the W_VL cycle, and the sequence takes 4 writes.
- Undefined: a 3-write sequence with no vl write; the W_VL state does not exist.

Test Plan:
- Reset value check: reset asserted mid-operation -> immediately c_we=0, busy=0, done=0, s_gnt=0. After release, a single s_req with reg=5, data=0x1234 -> s_gnt same cycle, next cycle c_we=1, c_reg=5, c_writedatain=0x1234.
- cfg arows=3, acols=8, bcols=0 -> three consecutive c_we cycles: (31,0x07), (30,0xFF), (29,0x00). done on the third. busy high for exactly 3 cycles. With VCTRL_SETVL_EN, a fourth write (0,0x0) follows with done on it.
- cfg arows=4, bcols=6, with VCTRL_SETVL_EN -> the vl write is (0, 24) decimal.
- Field value 15 with MMSIZE=8 -> mask saturates to 0xFF.
- Continuous s_req and cfg_valid from reset -> grants alternate scalar, cfg, scalar, and so on. No scalar c_we appears between 31/30/29. s_gnt stays low while busy.
- Reset asserted during W_ACOLS -> c_we drops immediately. After release, no reg-29 write appears, and the next cfg starts cleanly at reg 31.
